// File: rtl/demux1_2_buf.sv
// demux1_2_buf: routes one input stream into two independent 2-entry output queues.
// Latency: 1 cycle from input acceptance to out*_valid; no same-cycle bypass.
// Backpressure: in_ready drops only when the selected queue is full; the other queue keeps flowing.
//
// Ports:
//   clk, reset                 - clock (rising edge), asynchronous active-high reset
//   in_data/in_valid/in_sel    - producer word, offer strobe, destination select (0/1)
//   in_ready                   - selected queue has room (registered counts only)
//   out0_*/out1_*              - per-queue head word, valid, consumer ready, occupancy (0..2)

// Generic 2-entry FIFO: push and pop are requests, ignored when full / empty.
// Ports: push/wdata write side, pop read side, head = oldest word, count = occupancy.
module demux1_2_buf_fifo #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [N-1:0] wdata,
  input  logic         pop,
  output logic [N-1:0] head,
  output logic [1:0]   count
);

  logic [N-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  // A full FIFO refuses the push even if it pops in the same cycle.
  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head comes from storage only, so there is no path from wdata to head.
  assign head = mem[rd_ptr];

endmodule

module demux1_2_buf #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_sel,
  output logic         in_ready,
  output logic [N-1:0] out0_data,
  output logic         out0_valid,
  input  logic         out0_ready,
  output logic [1:0]   out0_count,
  output logic [N-1:0] out1_data,
  output logic         out1_valid,
  input  logic         out1_ready,
  output logic [1:0]   out1_count
);

  logic push0;
  logic push1;

  // Readiness looks only at the selected queue's registered count, never at out*_ready.
  assign in_ready = in_sel ? (out1_count != 2'd2) : (out0_count != 2'd2);

  assign push0 = in_valid && in_ready && !in_sel;
  assign push1 = in_valid && in_ready && in_sel;

  demux1_2_buf_fifo #(.N(N)) u_q0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .wdata (in_data),
    .pop   (out0_ready),
    .head  (out0_data),
    .count (out0_count)
  );

  demux1_2_buf_fifo #(.N(N)) u_q1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .wdata (in_data),
    .pop   (out1_ready),
    .head  (out1_data),
    .count (out1_count)
  );

  assign out0_valid = (out0_count != 2'd0);
  assign out1_valid = (out1_count != 2'd0);

endmodule

// File: tb/tb_demux1_2_buf.sv
// Bench for demux1_2_buf: directed scenarios plus 10000 random cycles against a queue model.
module tb_demux1_2_buf;
  localparam int N = 32;

  logic         clk;
  logic         reset;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_sel;
  logic         in_ready;
  logic [N-1:0] out0_data;
  logic         out0_valid;
  logic         out0_ready;
  logic [1:0]   out0_count;
  logic [N-1:0] out1_data;
  logic         out1_valid;
  logic         out1_ready;
  logic [1:0]   out1_count;

  demux1_2_buf #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_count (out0_count),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_count (out1_count)
  );

  // Reference model: one queue of accepted words per output.
  logic [N-1:0] q0[$];
  logic [N-1:0] q1[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  chk_on   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [N-1:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  // Decide transfers from the model's occupancy, advance one edge, then update the model.
  task automatic tick();
    bit acc, p0, p1;
    logic [N-1:0] d;
    logic s;
    acc = !reset && in_valid && ((in_sel ? q1.size() : q0.size()) != 2);
    p0  = !reset && out0_ready && (q0.size() != 0);
    p1  = !reset && out1_ready && (q1.size() != 0);
    d   = in_data;
    s   = in_sel;
    @(posedge clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    #1;
  endtask

  // Every cycle: compare all outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", in_ready, ((in_sel ? q1.size() : q0.size()) != 2));
      chk("out0_count", out0_count, q0.size());
      chk("out1_count", out1_count, q1.size());
      chk("out0_valid", out0_valid, q0.size() != 0);
      chk("out1_valid", out1_valid, q1.size() != 0);
      if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
      if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
    end
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    // Reset state, independent of clock.
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data", out0_data, 0);
    chk("rst_out1_data", out1_data, 0);
    chk("rst_out0_count", out0_count, 0);
    chk("rst_out1_count", out1_count, 0);
    chk("rst_in_ready", in_ready, 1);
    // Offers during reset are not recorded.
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    chk("rst_no_push", out0_count, 0);
    reset = 1'b0;
    chk_on = 1'b1;

    // First word, one cycle latency.
    drive(1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("first_valid", out0_valid, 1);
    chk("first_data", out0_data, 32'hA5A5_A5A5);
    chk("first_count", out0_count, 1);
    chk("first_out1_valid", out1_valid, 0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick();

    // Fill queue 1; queue 0 stays open.
    drive(1'b1, 1'b1, 32'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
    #1;
    chk("full1_count", out1_count, 2);
    chk("full1_ready_sel1", in_ready, 0);
    chk("model_q1_size", q1.size(), 2);
    in_sel = 1'b0;
    #1;
    chk("full1_ready_sel0", in_ready, 1);
    drive(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
    tick();
    chk("other_side_accept", out0_count, 1);
    chk("full1_head", out1_data, 32'h1);

    // Full queue refuses push even while popping.
    drive(1'b1, 1'b1, 32'h3, 1'b0, 1'b1);
    tick();
    chk("refused_count", out1_count, 1);
    chk("refused_head", out1_data, 32'h2);
    drive(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
    tick();
    chk("retry_count", out1_count, 2);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tick();
    chk("order_third", out1_data, 32'h3);
    tick();
    chk("drained1", out1_count, 0);

    // Simultaneous push/pop at count 1 across several pointer wraps.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 32'h40 + i, 1'b1, 1'b0);
      tick();
      chk("pp_count", out0_count, 1);
      chk("pp_head", out0_data, 32'h40 + i);
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick();

    // Two words per queue, then reset between edges.
    drive(1'b1, 1'b0, 32'h21, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 32'h31, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 32'h22, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 32'h32, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_count0", out0_count, 2);
    chk("pre_rst_count1", out1_count, 2);
    chk("model_q0_size", q0.size(), 2);
    #2;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("mid_rst_valid0", out0_valid, 0);
    chk("mid_rst_valid1", out1_valid, 0);
    chk("mid_rst_data0", out0_data, 0);
    chk("mid_rst_data1", out1_data, 0);
    chk("mid_rst_count0", out0_count, 0);
    chk("mid_rst_count1", out1_count, 0);
    chk("mid_rst_ready", in_ready, 1);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h7, 1'b0, 1'b0);
    #1;
    chk("post_rst_no_bypass", out0_valid, 0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_valid", out0_valid, 1);
    chk("post_rst_data", out0_data, 32'h7);

    // Random traffic; the per-cycle compare process checks every output.
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), N'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    chk("final_drain0", out0_count, 0);
    chk("final_drain1", out1_count, 0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
